// File: rtl/inst_rom_loader.sv
// Instruction store for the core's fetch port, filled by a byte-serial boot loader.
// The core is held in reset until a load with a good checksum completes.
module inst_rom_loader #(
    parameter int unsigned AW    = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] inst_o,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_byte_i,
    output logic        ld_ready_o,
    output logic        cpu_rst_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [2:0] {
        StIdle, StCntHi, StCntLo, StData, StCsum, StRun, StErr
    } state_t;

    state_t           state;
    logic [7:0]       cnt_hi;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] wcnt;
    logic [1:0]       lane;
    logic [23:0]      wbuf;
    logic [7:0]       csum;
    logic [31:0]      store [Depth];

    logic             fire;
    logic             wr_en;
    logic [CNT_W-1:0] count_next;
    logic [AW-1:0]    rd_idx;
    logic             unused_addr;

    assign ld_ready_o = (state == StCntHi) || (state == StCntLo) ||
                        (state == StData)  || (state == StCsum);
    assign fire       = ld_valid_i && ld_ready_o;
    assign count_next = CNT_W'({cnt_hi, ld_byte_i});
    // Gated by rst so a byte landing in the reset cycle cannot touch the store
    assign wr_en      = !rst && fire && (state == StData) && (lane == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            cpu_rst_o   <= 1'b1;
            load_done_o <= 1'b0;
            load_err_o  <= 1'b0;
            cnt_hi      <= '0;
            count       <= '0;
            wcnt        <= '0;
            lane        <= '0;
            wbuf        <= '0;
            csum        <= '0;
        end else begin
            case (state)
                StIdle: state <= StCntHi;
                StCntHi: begin
                    if (fire) begin
                        cnt_hi <= ld_byte_i;
                        state  <= StCntLo;
                    end
                end
                StCntLo: begin
                    if (fire) begin
                        count <= count_next;
                        wcnt  <= '0;
                        lane  <= '0;
                        csum  <= '0;
                        if (count_next == '0) begin
                            state <= StCsum;
                        end else if (32'(count_next) > Depth) begin
                            state      <= StErr;
                            load_err_o <= 1'b1;
                        end else begin
                            state <= StData;
                        end
                    end
                end
                StData: begin
                    if (fire) begin
                        csum <= csum ^ ld_byte_i;
                        lane <= lane + 2'd1;
                        wbuf <= {wbuf[15:0], ld_byte_i};
                        if (lane == 2'd3) begin
                            wcnt <= wcnt + 1'b1;
                            if (wcnt == count - 1'b1) state <= StCsum;
                        end
                    end
                end
                StCsum: begin
                    if (fire) begin
                        if (ld_byte_i == csum) begin
                            state       <= StRun;
                            cpu_rst_o   <= 1'b0;
                            load_done_o <= 1'b1;
                        end else begin
                            state      <= StErr;
                            load_err_o <= 1'b1;
                        end
                    end
                end
                StRun:   state <= StRun;
                StErr:   state <= StErr;
                default: state <= StIdle;
            endcase
        end
    end

    // Store is deliberately not reset; the index wraps after a full-depth load
    always_ff @(posedge clk) begin
        if (wr_en) store[wcnt[AW-1:0]] <= {wbuf, ld_byte_i};
    end

    assign rd_idx      = addr_i[AW+1:2];
    assign inst_o      = (ce_i && (state == StRun)) ? store[rd_idx] : 32'h0;
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: loads via the byte port, then checks fetch reads.
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] inst;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_ready;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] words[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] full_word2;

    inst_rom_loader #(.AW(10), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce),
        .addr_i      (addr),
        .inst_o      (inst),
        .ld_valid_i  (ld_valid),
        .ld_byte_i   (ld_byte),
        .ld_ready_o  (ld_ready),
        .cpu_rst_o   (cpu_rst),
        .load_done_o (load_done),
        .load_err_o  (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b1;
        ld_valid = 1'b0;
        ce = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offers one byte and returns at the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n;
        n = 0;
        if (stall) begin
            while ($urandom_range(1) == 0) begin
                ld_valid = 1'b0;
                ld_byte  = 8'($urandom);
                @(negedge clk);
            end
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        while (!ld_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!ld_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: ld_ready=%b required 1", ld_ready);
        end else begin
            @(negedge clk);
        end
        ld_valid = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] cnt, input logic [7:0] flip, input bit stall,
                           input bit ok, input string tag);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        send_byte(cnt[15:8], stall);
        send_byte(cnt[7:0], stall);
        foreach (words[i]) begin
            for (int k = 3; k >= 0; k--) begin
                b = words[i][8*k +: 8];
                cs ^= b;
                send_byte(b, stall);
            end
        end
        checks++;
        if (cpu_rst !== 1'b1 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_pre_csum: cpu_rst=%b done=%b required 1 0", tag, cpu_rst, load_done);
        end
        send_byte(cs ^ flip, stall);
        checks++;
        if ({cpu_rst, load_done, load_err} !== (ok ? 3'b010 : 3'b101)) begin
            errors++;
            $display("FAIL %s_post_csum: rst/done/err=%b required %b", tag,
                     {cpu_rst, load_done, load_err}, ok ? 3'b010 : 3'b101);
        end
        foreach (words[i]) begin
            exp_addr_q.push_back(32'(i) * 4);
            exp_data_q.push_back(ok ? words[i] : 32'h0);
        end
    endtask

    task automatic drain_reads(input string tag);
        logic [31:0] a;
        logic [31:0] e;
        while (exp_addr_q.size() > 0) begin
            a = exp_addr_q.pop_front();
            e = exp_data_q.pop_front();
            ce = 1'b1;
            addr = a;
            #1;
            checks++;
            if (inst !== e) begin
                errors++;
                $display("FAIL %s_read addr=%h: inst=%h required %h", tag, a, inst, e);
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({ld_ready, cpu_rst, load_done, load_err} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_outputs: rdy/rst/done/err=%b required 0100",
                     {ld_ready, cpu_rst, load_done, load_err});
        end
        rst = 1'b0;
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ready: ld_ready=%b required 0", ld_ready);
        end
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cnt_hi_ready: ld_ready=%b required 1", ld_ready);
        end
    endtask

    task automatic test_valid_load();
        apply_reset();
        words = '{32'h3C010101, 32'h34220020};
        do_load(16'h0002, 8'h00, 1'b0, 1'b1, "valid");
        exp_addr_q.push_back(32'h6);    exp_data_q.push_back(32'h34220020);
        exp_addr_q.push_back(32'h1004); exp_data_q.push_back(32'h34220020);
        drain_reads("valid");
    endtask

    task automatic test_bad_csum();
        apply_reset();
        words = '{32'h3C010101, 32'h34220020};
        do_load(16'h0002, 8'h01, 1'b0, 1'b0, "badcsum");
        exp_addr_q.push_back(32'h6); exp_data_q.push_back(32'h0);
        drain_reads("badcsum");
    endtask

    task automatic test_oversize();
        apply_reset();
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        checks++;
        if ({ld_ready, cpu_rst, load_err} !== 3'b011) begin
            errors++;
            $display("FAIL oversize_err: rdy/rst/err=%b required 011", {ld_ready, cpu_rst, load_err});
        end
        ld_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ld_byte = 8'($urandom);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        checks++;
        if ({ld_ready, load_done, load_err} !== 3'b001) begin
            errors++;
            $display("FAIL oversize_hold: rdy/done/err=%b required 001",
                     {ld_ready, load_done, load_err});
        end
    endtask

    task automatic test_zero();
        apply_reset();
        words.delete();
        do_load(16'h0000, 8'h00, 1'b0, 1'b1, "zero");
        // Earlier contents survive: the oversize header must not have written anything
        exp_addr_q.push_back(32'h0); exp_data_q.push_back(32'h3C010101);
        exp_addr_q.push_back(32'h4); exp_data_q.push_back(32'h34220020);
        drain_reads("zero");
        for (int i = 0; i < 4; i++) begin
            ce = 1'b0;
            addr = $urandom;
            #1;
            checks++;
            if (inst !== 32'h0) begin
                errors++;
                $display("FAIL zero_ce_off addr=%h: inst=%h required 0", addr, inst);
            end
        end
    endtask

    task automatic test_reset_midload();
        apply_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        apply_reset();
        words = '{32'hDEADBEEF};
        do_load(16'h0001, 8'h00, 1'b0, 1'b1, "midload");
        exp_addr_q.push_back(32'h4); exp_data_q.push_back(32'h34220020);
        drain_reads("midload");
    endtask

    task automatic test_full();
        apply_reset();
        words.delete();
        for (int i = 0; i < 1024; i++) words.push_back($urandom);
        full_word2 = words[2];
        do_load(16'h0400, 8'h00, 1'b0, 1'b1, "full");
        drain_reads("full");
    endtask

    task automatic test_stall();
        apply_reset();
        words = '{32'h3C010101, 32'h34220020};
        do_load(16'h0002, 8'h00, 1'b1, 1'b1, "stall");
        ld_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ld_byte = 8'($urandom);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        checks++;
        if ({ld_ready, cpu_rst, load_done} !== 3'b001) begin
            errors++;
            $display("FAIL stall_run_hold: rdy/rst/done=%b required 001",
                     {ld_ready, cpu_rst, load_done});
        end
        exp_addr_q.push_back(32'h8); exp_data_q.push_back(full_word2);
        drain_reads("stall");
    endtask

    initial begin
        test_reset();
        test_valid_load();
        test_bad_csum();
        test_oversize();
        test_zero();
        test_reset_midload();
        test_full();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
